corr_window_sequencer: RTL

Controller for the v7 quad correlator power-sum datapath: the partition/preadd stage followed by the six-stage DSP adder cascade. It gates the cascade, waits out its pipeline fill, then accumulates the per-cycle sum of 16 squared samples over a programmable window. Each window yields a total, a peak sample and the peak's position, handed downstream with a valid/ready handshake. It runs single-shot or back-to-back continuous windows, and sits between trigger-control registers and the L1 threshold logic.

---
 rtl/glitc_corr_pkg.sv | 25 ++
 rtl/corr_window_peak_tracker.sv | 55 +++++
 rtl/corr_window_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/glitc_corr_pkg.sv
// Purpose: shared types and constants for the quad correlator power-sum path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the controller state encoding and the cascade fill latency.
// The partition/preadd and cascade owners reference the same value.
package glitc_corr_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ACCUM = 2'd2
  } corr_state_e;

  // Cycles from cascade enable to first valid cascade output:
  // 1 preadd stage + 6 DSP adder stages.
  localparam int unsigned CASCADE_LAT_DEFAULT = 7;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corr_window_peak_tracker.sv
// Purpose: running peak and peak-position register for one accumulation window.
// Latency: 1 cycle to the registered running peak; cand_* is combinational.
// Backpressure: none; follows load/en from the sequencer every cycle.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              first sample of a window: peak/index take sample unconditionally
//   en                later sample: replace only on strictly greater value
//   idx               position of the current sample within the window
//   sample            current cascade output
//   cand_peak/idx     peak/index including this cycle's sample (for publishing)
module window_peak_tracker #(
  parameter int unsigned SUMBITS = 12,
  parameter int unsigned WINBITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [WINBITS-1:0] idx,
  input  logic [SUMBITS-1:0] sample,
  output logic [SUMBITS-1:0] cand_peak,
  output logic [WINBITS-1:0] cand_idx
);

  logic [SUMBITS-1:0] peak_q, peak_d;
  logic [WINBITS-1:0] pidx_q, pidx_d;

  // Strict compare so equal values keep the earliest position.
  always_comb begin
    peak_d = peak_q;
    pidx_d = pidx_q;
    if (load) begin
      peak_d = sample;
      pidx_d = idx;
    end else if (en && (sample > peak_q)) begin
      peak_d = sample;
      pidx_d = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      pidx_q <= '0;
    end else begin
      peak_q <= peak_d;
      pidx_q <= pidx_d;
    end
  end

  assign cand_peak = peak_d;
  assign cand_idx  = pidx_d;

endmodule

// File: rtl/corr_window_sequencer.sv
// Purpose: gates the correlator cascade, waits out its fill, sums squared samples per window.
// Latency: START to RESULT_VALID = CASCADE_LAT + N + 1 cycles; continuous mode one result per N.
// Backpressure: single result slot; a window completing while the slot is full and not
//               being consumed is dropped and OVERFLOW is set (sticky).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   START/ABORT             begin (IDLE only) / cancel; ABORT wins
//   CONTINUOUS, WINDOW      mode and window length minus one, latched with START
//   SUM_IN                  cascade output sample, unsigned
//   CASCADE_CE, BUSY        cascade clock enable, non-IDLE indicator
//   RESULT/PEAK/PEAK_IDX    window total, largest sample, its offset
//   RESULT_VALID/READY      result handshake
//   OVERFLOW                sticky dropped-window flag, cleared by an accepted START
module corr_window_sequencer
  import glitc_corr_pkg::*;
#(
  parameter int unsigned SUMBITS     = 12,
  parameter int unsigned CASCADE_LAT = CASCADE_LAT_DEFAULT,
  parameter int unsigned WINBITS     = 8,
  localparam int unsigned ACCBITS    = SUMBITS + WINBITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               START,
  input  logic               ABORT,
  input  logic               CONTINUOUS,
  input  logic [WINBITS-1:0] WINDOW,
  input  logic [SUMBITS-1:0] SUM_IN,
  output logic               CASCADE_CE,
  output logic               BUSY,
  output logic [ACCBITS-1:0] RESULT,
  output logic [SUMBITS-1:0] PEAK,
  output logic [WINBITS-1:0] PEAK_IDX,
  output logic               RESULT_VALID,
  input  logic               RESULT_READY,
  output logic               OVERFLOW
);

  localparam int unsigned FILLBITS = cnt_width(CASCADE_LAT);
  localparam logic [FILLBITS-1:0] FILL_LAST = FILLBITS'(CASCADE_LAT - 1);

  corr_state_e state_q, state_d;

  logic [FILLBITS-1:0] fill_cnt_q, fill_cnt_d;
  logic [WINBITS-1:0]  win_q, win_d;
  logic                cont_q, cont_d;
  logic [WINBITS-1:0]  idx_q, idx_d;
  logic [ACCBITS-1:0]  acc_q, acc_d;

  logic [ACCBITS-1:0]  res_q, res_d;
  logic [SUMBITS-1:0]  peak_q, peak_d;
  logic [WINBITS-1:0]  pidx_q, pidx_d;
  logic                res_vld_q, res_vld_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                ce_q, ce_d;

  logic                take;      // a sample is accumulated this cycle
  logic                done;      // this cycle's sample closes the window
  logic                first;     // this cycle's sample opens the window
  logic [SUMBITS-1:0]  cand_peak;
  logic [WINBITS-1:0]  cand_idx;

  window_peak_tracker #(
    .SUMBITS (SUMBITS),
    .WINBITS (WINBITS)
  ) u_peak (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (first),
    .en        (take),
    .idx       (idx_q),
    .sample    (SUM_IN),
    .cand_peak (cand_peak),
    .cand_idx  (cand_idx)
  );

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    win_d      = win_q;
    cont_d     = cont_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    res_d      = res_q;
    peak_d     = peak_q;
    pidx_d     = pidx_q;
    res_vld_d  = res_vld_q;
    ovf_d      = ovf_q;
    take       = 1'b0;
    done       = 1'b0;
    first      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          win_d      = WINDOW;
          cont_d     = CONTINUOUS;
          ovf_d      = 1'b0;
          fill_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end

      ST_FILL: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (fill_cnt_q == FILL_LAST) begin
          idx_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          fill_cnt_d = fill_cnt_q + FILLBITS'(1);
        end
      end

      ST_ACCUM: begin
        if (ABORT) begin
          // Partial window is simply abandoned; index 0 reloads everything.
          state_d = ST_IDLE;
        end else begin
          take  = 1'b1;
          first = (idx_q == '0);
          acc_d = first ? ACCBITS'(SUM_IN) : acc_q + ACCBITS'(SUM_IN);
          if (idx_q == win_q) begin
            done  = 1'b1;
            idx_d = '0;
            if (!cont_q) state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + WINBITS'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Result slot: completion loads when the slot is free or being drained
    // this cycle; otherwise the window is lost and flagged.
    if (done) begin
      if (!res_vld_q || RESULT_READY) begin
        res_d     = acc_d;
        peak_d    = cand_peak;
        pidx_d    = cand_idx;
        res_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (res_vld_q && RESULT_READY) begin
      res_vld_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    ce_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      win_q      <= '0;
      cont_q     <= 1'b0;
      idx_q      <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      peak_q     <= '0;
      pidx_q     <= '0;
      res_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      win_q      <= win_d;
      cont_q     <= cont_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      peak_q     <= peak_d;
      pidx_q     <= pidx_d;
      res_vld_q  <= res_vld_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      ce_q       <= ce_d;
    end
  end

  assign CASCADE_CE   = ce_q;
  assign BUSY         = busy_q;
  assign RESULT       = res_q;
  assign PEAK         = peak_q;
  assign PEAK_IDX     = pidx_q;
  assign RESULT_VALID = res_vld_q;
  assign OVERFLOW     = ovf_q;

endmodule
